ila_trigger_seq: RTL and testbench
==================================

# ila_trigger_seq

Multi-stage trigger sequencer directly upstream of the ILA: it watches the probed signal bus, walks a programmable sequence of up to STAGES value/mask match conditions with per-stage occurrence counts, and raises a level trigger that drives one bit of the ILA trigger input. Configuration comes from the ILA software register file. It runs on the sampling clock domain so the trigger is cycle-aligned with the samples the ILA captures.

## Interface
- SIGNAL_W, 32, width of the probed signal bus
- STAGES, 4, number of sequencer stages (power of two, 2..16)
- STG_W, 2, log2(STAGES)
- CNT_W, 16, width of the per-stage occurrence count
- clk  in  1  sampling clock, rising edge
- rst  in  1  asynchronous, active-high reset
- rst_soft  in  1  synchronous soft reset; returns to IDLE
- arm  in  1  one-cycle pulse; starts (or restarts) the sequence at stage 0
- signal  in  SIGNAL_W  probed bus, same signal the ILA samples
- cfg_value  in  STAGES*SIGNAL_W  per-stage compare value, stage k at bits [k*SIGNAL_W +: SIGNAL_W]
- cfg_mask  in  STAGES*SIGNAL_W  per-stage care mask (1 = compare bit)
- cfg_count  in  STAGES*CNT_W  per-stage required match occurrences (0 treated as 1)
- cfg_consec  in  STAGES  per-stage: 1 = matches must be consecutive
- cfg_last  in  STG_W  index of final stage
- trigger  out  1  sequence complete; level, to ILA trigger input
- armed  out  1  sequencer running (stages being evaluated)
- stage  out  STG_W  current stage index
- occ  out  CNT_W  matches counted in current stage

## Operation
- Input register: signal captured into sig_q every cycle; all comparisons use sig_q.
- Match for stage k: ((sig_q ^ value_k) & mask_k) == 0. Mask all zero ⇒ always match.
- Target for stage k: tgt_k = (cfg_count_k == 0) ? 1 : cfg_count_k.
- States: IDLE, RUN, FIRED.
- IDLE: trigger=0, armed=0. arm ⇒ RUN, stage=0, occ=0.
- RUN (armed=1), per cycle with current stage s:
  - match and occ+1 == tgt_s and s == cfg_last ⇒ FIRED, occ cleared.
  - match and occ+1 == tgt_s and s != cfg_last ⇒ stage=s+1, occ=0.
  - match otherwise ⇒ occ=occ+1.
  - no match and cfg_consec_s ⇒ occ=0; no match and not consec ⇒ occ held.
- FIRED: trigger=1, armed=0, stage holds cfg_last; holds until rst_soft or arm.
- arm in any state (including RUN or FIRED) ⇒ RUN, stage=0, occ=0, trigger cleared next cycle.
- Priority: rst > rst_soft > arm > sequence update. rst_soft and arm in same cycle ⇒ IDLE.
- cfg_last ≥ STAGES impossible by width; cfg_last=0 ⇒ single-stage trigger.
- Configuration read live; software changes it only in IDLE (no shadowing, behaviour undefined otherwise).
- occ arithmetic in CNT_W bits; occ+1 never wraps because advance occurs at tgt ≤ 2^CNT_W−1.

## Timing
- Reset values: trigger=0, armed=0, stage=0, occ=0, sig_q=0, state IDLE.
- arm pulse at cycle N ⇒ armed=1 from N+1; sig_q from cycle N+1 onward (signal at N) is evaluated.
- Latency: signal value at cycle N completing the final match ⇒ trigger=1 at cycle N+2 (1 input register + 1 state register).
- Stage advance: one stage per cycle maximum; a single sig_q value never satisfies two stages.
- All outputs registered; no combinational path from signal or config to outputs.
- rst asserted mid-sequence ⇒ immediate return to reset values, independent of clk.

## Test plan
- Single stage: cfg_last=0, value0=0xA5, mask0=0xFF, count0=0; arm, then signal=0xA5 at cycle N ⇒ trigger=1 at N+2, armed=0, stays high 10 cycles.
- Mask and count: mask0=0x0F, value0=0x05, count0=3, consec0=0; drive 0x15, 0x00, 0xF5, 0x00, 0x25 ⇒ occ 1,1,2,2 then trigger 2 cycles after 0x25.
- Consecutive reset: consec0=1, count0=3; drive match, match, miss, match, match, match ⇒ occ 1,2,0,1,2, trigger only after 6th cycle.
- Three-stage sequence: values 0x1,0x2,0x3, cfg_last=2; drive 0x2,0x1,0x1,0x3,0x2,0x3 ⇒ stage 0→1 after 0x1, 1→2 after 0x2, trigger after final 0x3; stage reads 2.
- Re-arm/soft reset: while FIRED pulse arm ⇒ trigger=0, stage=0, armed=1 next cycle; same cycle arm+rst_soft ⇒ IDLE, armed=0.
- Async reset mid-RUN (stage=1, occ=5): assert rst between edges ⇒ all outputs 0 immediately; after release, no trigger without new arm.

Source files
------------

// File: rtl/ila_trigger_seq.sv
// ila_trigger_seq: multi-stage value/mask trigger sequencer feeding one ILA
// trigger input. It compares a registered copy of the probed bus against the
// current stage's condition and counts occurrences per stage. When the final
// stage completes, it raises a level trigger.
module ila_trigger_seq #(
  parameter int SIGNAL_W = 32,
  parameter int STAGES   = 4,
  parameter int STG_W    = 2,
  parameter int CNT_W    = 16
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      rst_soft,
  input  logic                      arm,
  input  logic [SIGNAL_W-1:0]        signal,
  input  logic [STAGES*SIGNAL_W-1:0] cfg_value,
  input  logic [STAGES*SIGNAL_W-1:0] cfg_mask,
  input  logic [STAGES*CNT_W-1:0]    cfg_count,
  input  logic [STAGES-1:0]          cfg_consec,
  input  logic [STG_W-1:0]           cfg_last,
  output logic                      trigger,
  output logic                      armed,
  output logic [STG_W-1:0]           stage,
  output logic [CNT_W-1:0]           occ
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_FIRED = 2'd2
  } state_t;

  state_t              r_state;
  state_t              w_state_nxt;
  logic [SIGNAL_W-1:0] r_sig_q;
  logic [STG_W-1:0]    r_stage;
  logic [STG_W-1:0]    w_stage_nxt;
  logic [CNT_W-1:0]    r_occ;
  logic [CNT_W-1:0]    w_occ_nxt;
  logic                r_trigger;
  logic                r_armed;
  logic                w_trigger_nxt;
  logic                w_armed_nxt;

  // Per-stage configuration unpacked so the current stage is a plain index.
  logic [SIGNAL_W-1:0] w_value_arr [STAGES];
  logic [SIGNAL_W-1:0] w_mask_arr  [STAGES];
  logic [CNT_W-1:0]    w_count_arr [STAGES];

  for (genvar k = 0; k < STAGES; k++) begin : g_cfg
    assign w_value_arr[k] = cfg_value[k*SIGNAL_W +: SIGNAL_W];
    assign w_mask_arr[k]  = cfg_mask[k*SIGNAL_W +: SIGNAL_W];
    assign w_count_arr[k] = cfg_count[k*CNT_W +: CNT_W];
  end

  logic             w_match;
  logic [CNT_W-1:0] w_tgt;
  logic [CNT_W-1:0] w_occ_inc;
  logic             w_stage_done;

  // A zero count means "one occurrence". This keeps the advance compare
  // reachable, and occ+1 can never wrap before it hits the target.
  assign w_match      = ((r_sig_q ^ w_value_arr[r_stage]) & w_mask_arr[r_stage]) == '0;
  assign w_tgt        = (w_count_arr[r_stage] == '0) ? CNT_W'(1) : w_count_arr[r_stage];
  assign w_occ_inc    = r_occ + CNT_W'(1);
  assign w_stage_done = w_match && (w_occ_inc == w_tgt);

  // Input register: every comparison uses the bus as sampled one cycle ago.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sig_q <= '0;
    end else begin
      // NOTE: non-blocking assignments in clocked blocks so all flops update
      // from pre-edge values regardless of statement order.
      r_sig_q <= signal;
    end
  end

  // State register: FSM state, stage/occurrence counters and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_stage   <= '0;
      r_occ     <= '0;
      r_trigger <= 1'b0;
      r_armed   <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_stage   <= w_stage_nxt;
      r_occ     <= w_occ_nxt;
      r_trigger <= w_trigger_nxt;
      r_armed   <= w_armed_nxt;
    end
  end

  // Next-state logic: soft reset beats arm, and arm beats the sequence update.
  always_comb begin
    // NOTE: every comb output gets a default first, so no path infers a latch.
    w_state_nxt = r_state;
    w_stage_nxt = r_stage;
    w_occ_nxt   = r_occ;
    if (rst_soft) begin
      w_state_nxt = S_IDLE;
      w_stage_nxt = '0;
      w_occ_nxt   = '0;
    end else if (arm) begin
      w_state_nxt = S_RUN;
      w_stage_nxt = '0;
      w_occ_nxt   = '0;
    end else begin
      case (r_state)
        S_RUN: begin
          if (w_stage_done) begin
            w_occ_nxt = '0;
            if (r_stage == cfg_last) begin
              // Stage index stays at the final stage while FIRED.
              w_state_nxt = S_FIRED;
            end else begin
              w_stage_nxt = r_stage + STG_W'(1);
            end
          end else if (w_match) begin
            w_occ_nxt = w_occ_inc;
          end else if (cfg_consec[r_stage]) begin
            w_occ_nxt = '0;
          end
        end
        default: ;
      endcase
    end
  end

  // Output decode from the next state, so both outputs come straight off flops.
  always_comb begin
    w_trigger_nxt = (w_state_nxt == S_FIRED);
    w_armed_nxt   = (w_state_nxt == S_RUN);
  end

  assign trigger = r_trigger;
  assign armed   = r_armed;
  assign stage   = r_stage;
  assign occ     = r_occ;

endmodule

// File: tb/tb_ila_trigger_seq.sv
// Self-checking bench for ila_trigger_seq. It runs directed scenarios and
// randomized traffic against a cycle-level behavioural model of the
// sequencing rules.
module tb_ila_trigger_seq;

  localparam int SIGNAL_W = 32;
  localparam int STAGES   = 4;
  localparam int STG_W    = 2;
  localparam int CNT_W    = 16;

  logic                      clk;
  logic                      rst;
  logic                      rst_soft;
  logic                      arm;
  logic [SIGNAL_W-1:0]        signal;
  logic [STAGES*SIGNAL_W-1:0] cfg_value;
  logic [STAGES*SIGNAL_W-1:0] cfg_mask;
  logic [STAGES*CNT_W-1:0]    cfg_count;
  logic [STAGES-1:0]          cfg_consec;
  logic [STG_W-1:0]           cfg_last;
  logic                      trigger;
  logic                      armed;
  logic [STG_W-1:0]           stage;
  logic [CNT_W-1:0]           occ;

  ila_trigger_seq #(
    .SIGNAL_W(SIGNAL_W), .STAGES(STAGES), .STG_W(STG_W), .CNT_W(CNT_W)
  ) dut (
    .clk(clk), .rst(rst), .rst_soft(rst_soft), .arm(arm), .signal(signal),
    .cfg_value(cfg_value), .cfg_mask(cfg_mask), .cfg_count(cfg_count),
    .cfg_consec(cfg_consec), .cfg_last(cfg_last),
    .trigger(trigger), .armed(armed), .stage(stage), .occ(occ)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Configuration as software sees it.
  logic [31:0] c_val [STAGES];
  logic [31:0] c_msk [STAGES];
  int          c_cnt [STAGES];
  bit          c_con [STAGES];
  int          c_last;

  task automatic apply_cfg();
    for (int k = 0; k < STAGES; k++) begin
      cfg_value[k*SIGNAL_W +: SIGNAL_W] = c_val[k];
      cfg_mask[k*SIGNAL_W +: SIGNAL_W]  = c_msk[k];
      cfg_count[k*CNT_W +: CNT_W]       = CNT_W'(c_cnt[k]);
      cfg_consec[k]                     = c_con[k];
    end
    cfg_last = STG_W'(c_last);
  endtask

  // Behavioural model: mode, current stage, occurrence count, and the
  // previously sampled bus value.
  localparam int M_IDLE = 0, M_RUN = 1, M_FIRED = 2;
  int          m_mode;
  int          m_stage;
  int          m_occ;
  logic [31:0] m_sq;

  task automatic model_reset();
    m_mode = M_IDLE; m_stage = 0; m_occ = 0; m_sq = '0;
  endtask

  task automatic model_step(input bit a, input bit s, input logic [31:0] sg);
    int tgt;
    bit hit;
    if (s) begin
      m_mode = M_IDLE; m_stage = 0; m_occ = 0;
    end else if (a) begin
      m_mode = M_RUN; m_stage = 0; m_occ = 0;
    end else if (m_mode == M_RUN) begin
      hit = ((m_sq ^ c_val[m_stage]) & c_msk[m_stage]) == 0;
      tgt = (c_cnt[m_stage] == 0) ? 1 : c_cnt[m_stage];
      if (hit) begin
        if (m_occ + 1 == tgt) begin
          m_occ = 0;
          if (m_stage == c_last) m_mode = M_FIRED;
          else m_stage = m_stage + 1;
        end else begin
          m_occ = m_occ + 1;
        end
      end else if (c_con[m_stage]) begin
        m_occ = 0;
      end
    end
    m_sq = sg;
  endtask

  // One clock: drive inputs, take the edge, advance the model, compare 1 ns later.
  task automatic cycle(input bit a, input bit s, input logic [31:0] sg);
    arm = a; rst_soft = s; signal = sg;
    @(posedge clk);
    #1;
    model_step(a, s, sg);
    check("trigger", 64'(trigger), 64'(m_mode == M_FIRED));
    check("armed",   64'(armed),   64'(m_mode == M_RUN));
    check("stage",   64'(stage),   64'(m_stage));
    check("occ",     64'(occ),     64'(m_occ));
    arm = 1'b0; rst_soft = 1'b0;
  endtask

  task automatic cfg_default();
    for (int k = 0; k < STAGES; k++) begin
      c_val[k] = '0; c_msk[k] = 32'hFF; c_cnt[k] = 0; c_con[k] = 1'b0;
    end
    c_last = 0;
  endtask

  initial begin
    rst = 1'b1; rst_soft = 1'b0; arm = 1'b0; signal = '0;
    cfg_default();
    apply_cfg();
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check("rst_trigger", 64'(trigger), 64'd0);
    check("rst_armed",   64'(armed),   64'd0);
    check("rst_stage",   64'(stage),   64'd0);
    check("rst_occ",     64'(occ),     64'd0);
    #3 rst = 1'b0;

    // Single stage: 0xA5 exact match, count 0 behaves as 1.
    begin
      cfg_default();
      c_val[0] = 32'hA5;
      apply_cfg();
      cycle(1'b1, 1'b0, 32'h00);
      check("t1_armed", 64'(armed), 64'd1);
      cycle(1'b0, 1'b0, 32'h00);
      cycle(1'b0, 1'b0, 32'hA5);
      check("t1_not_yet", 64'(trigger), 64'd0);
      cycle(1'b0, 1'b0, 32'h00);
      check("t1_trig_n2", 64'(trigger), 64'd1);
      check("t1_disarm",  64'(armed),   64'd0);
      for (int i = 0; i < 10; i++) begin
        cycle(1'b0, 1'b0, 32'(i));
        check("t1_hold", 64'(trigger), 64'd1);
      end
    end

    // Mask and count, non-consecutive.
    begin
      logic [31:0] s2 [6] = '{32'h15, 32'h00, 32'hF5, 32'h00, 32'h25, 32'h00};
      int          o2 [6] = '{0, 1, 1, 2, 2, 0};
      int          t2 [6] = '{0, 0, 0, 0, 0, 1};
      cycle(1'b0, 1'b1, 32'h0);
      cfg_default();
      c_val[0] = 32'h05; c_msk[0] = 32'h0F; c_cnt[0] = 3;
      apply_cfg();
      cycle(1'b1, 1'b0, 32'h00);
      for (int i = 0; i < 6; i++) begin
        cycle(1'b0, 1'b0, s2[i]);
        check("t2_occ",  64'(occ),     64'(o2[i]));
        check("t2_trig", 64'(trigger), 64'(t2[i]));
      end
    end

    // Consecutive count: a miss clears occ.
    begin
      logic [31:0] s3 [7] = '{32'h05, 32'h05, 32'h00, 32'h05, 32'h05, 32'h05, 32'h00};
      int          o3 [7] = '{0, 1, 2, 0, 1, 2, 0};
      int          t3 [7] = '{0, 0, 0, 0, 0, 0, 1};
      cycle(1'b0, 1'b1, 32'h0);
      cfg_default();
      c_val[0] = 32'h05; c_cnt[0] = 3; c_con[0] = 1'b1;
      apply_cfg();
      cycle(1'b1, 1'b0, 32'h00);
      for (int i = 0; i < 7; i++) begin
        cycle(1'b0, 1'b0, s3[i]);
        check("t3_occ",  64'(occ),     64'(o3[i]));
        check("t3_trig", 64'(trigger), 64'(t3[i]));
      end
    end

    // Three-stage sequence 1 -> 2 -> 3.
    begin
      logic [31:0] s4 [7] = '{32'h2, 32'h1, 32'h1, 32'h3, 32'h2, 32'h3, 32'h0};
      int          g4 [7] = '{0, 0, 1, 1, 1, 2, 2};
      int          t4 [7] = '{0, 0, 0, 0, 0, 0, 1};
      cycle(1'b0, 1'b1, 32'h0);
      cfg_default();
      c_val[0] = 32'h1; c_val[1] = 32'h2; c_val[2] = 32'h3; c_last = 2;
      apply_cfg();
      cycle(1'b1, 1'b0, 32'h00);
      for (int i = 0; i < 7; i++) begin
        cycle(1'b0, 1'b0, s4[i]);
        check("t4_stage", 64'(stage),   64'(g4[i]));
        check("t4_trig",  64'(trigger), 64'(t4[i]));
      end
    end

    // Re-arm while FIRED, then arm together with soft reset.
    cycle(1'b1, 1'b0, 32'h0);
    check("t5_rearm_trig",  64'(trigger), 64'd0);
    check("t5_rearm_stage", 64'(stage),   64'd0);
    check("t5_rearm_armed", 64'(armed),   64'd1);
    cycle(1'b1, 1'b1, 32'h0);
    check("t5_soft_armed", 64'(armed),   64'd0);
    check("t5_soft_trig",  64'(trigger), 64'd0);

    // Async reset at stage 1 with occ 5.
    begin
      cfg_default();
      c_val[0] = 32'h1; c_val[1] = 32'h2; c_cnt[1] = 10; c_last = 1;
      apply_cfg();
      cycle(1'b1, 1'b0, 32'h1);
      for (int i = 0; i < 6; i++) cycle(1'b0, 1'b0, 32'h2);
      check("t6_pre_stage", 64'(stage), 64'd1);
      check("t6_pre_occ",   64'(occ),   64'd5);
      #2 rst = 1'b1;
      #1;
      check("t6_async_trig",  64'(trigger), 64'd0);
      check("t6_async_armed", 64'(armed),   64'd0);
      check("t6_async_stage", 64'(stage),   64'd0);
      check("t6_async_occ",   64'(occ),     64'd0);
      #3 rst = 1'b0;
      model_reset();
      for (int i = 0; i < 15; i++) begin
        cycle(1'b0, 1'b0, (i % 2 == 0) ? 32'h1 : 32'h2);
        check("t6_no_trig", 64'(trigger), 64'd0);
      end
    end

    // Randomized traffic: new configuration after each soft reset.
    for (int r = 0; r < 25; r++) begin
      cycle(1'b0, 1'b1, $urandom);
      for (int k = 0; k < STAGES; k++) begin
        c_val[k] = $urandom_range(0, 15);
        c_msk[k] = ($urandom_range(0, 7) == 0) ? 32'h0 : 32'($urandom_range(0, 15));
        c_cnt[k] = $urandom_range(0, 4);
        c_con[k] = $urandom_range(0, 1);
      end
      c_last = $urandom_range(0, STAGES - 1);
      apply_cfg();
      for (int i = 0; i < 70; i++) begin
        cycle((i == 0) || ($urandom_range(0, 29) == 0),
              ($urandom_range(0, 79) == 0),
              ($urandom & 32'hFFFF_FF00) | 32'($urandom_range(0, 15)));
      end
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
